fsm_uart_rx: RTL and testbench

//  UART receiver: the receive end of the uart_tx link. Format is 8N1-style:
//  1 start bit, DATA_BITS data bits LSB first, no parity, 1 stop bit.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_rx_sync.sv | 33 +++
 rtl/fsm_uart_rx.sv | 122 ++++++++++++
 tb/tb_fsm_uart_rx.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receiver and transmitter.
//   uart_state_e : frame FSM states (2-bit encoding)
//   calc_cpb     : clocks per bit = clk_freq / baud (integer divide)
//   calc_half    : half a bit period, the start-bit sampling offset
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  function automatic int calc_cpb(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  function automatic int calc_half(input int clk_freq, input int baud);
    return calc_cpb(clk_freq, baud) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchroniser for the asynchronous rx line, plus one
// history flop for falling-edge detection. All flops reset high, which is
// the idle line level, so reset never produces a false start edge.
//   clk, rst_n  : clock, asynchronous active-low reset
//   rx_i        : raw serial line
//   rx_s        : synchronised line level
//   start_edge  : high for one cycle on a synchronised high->low transition
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rx_i,
  output logic rx_s,
  output logic start_edge
);

  logic meta;
  logic hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      rx_s <= 1'b1;
      hist <= 1'b1;
    end else begin
      meta <= rx_i;
      rx_s <= meta;
      hist <= rx_s;
    end
  end

  assign start_edge = hist & ~rx_s;

endmodule

// File: rtl/fsm_uart_rx.sv
// fsm_uart_rx: 8N1-style UART receiver (1 start, DATA_BITS data LSB first,
// no parity, 1 stop). Samples at mid-bit and strobes each received frame.
//   clk, rst_n : clock, asynchronous active-low reset
//   rx_i       : serial line, asynchronous, idles high
//   rx_data    : last good byte, held until the next good frame
//   rx_valid   : 1-cycle pulse, rx_data updated this cycle
//   frame_err  : 1-cycle pulse, stop bit sampled low (rx_data untouched)
//   busy       : high whenever the FSM is not IDLE
module fsm_uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 27_000_000,
  parameter int BAUD      = 115_200,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CPB  = calc_cpb(CLK_FREQ, BAUD);
  localparam int HALF = calc_half(CLK_FREQ, BAUD);
  localparam int CW   = $clog2(CPB);
  localparam int IW   = $clog2(DATA_BITS);

  localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  logic                 rx_s;
  logic                 start_edge;
  uart_state_e          state;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        idx;
  logic [DATA_BITS-1:0] shreg;

  uart_rx_sync u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_i       (rx_i),
    .rx_s       (rx_s),
    .start_edge (start_edge)
  );

  // busy is updated on every state transition so it tracks state != IDLE
  // exactly while still being a flop output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (start_edge) begin
            state <= START;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        START: begin
          // Re-check the line mid start bit to reject short glitches.
          if (cnt == CNT_HALF) begin
            cnt <= '0;
            if (!rx_s) begin
              state <= DATA;
              idx   <= '0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            // Shift in at the MSB so the first (LSB) bit ends up at bit 0.
            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            if (idx == IDX_LAST) state <= STOP;
            else                 idx   <= idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          // Leave at mid stop bit so a back-to-back start edge is caught.
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= IDLE;
            busy  <= 1'b0;
            if (rx_s) begin
              rx_data  <= shreg;
              rx_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fsm_uart_rx.sv
// Bench for fsm_uart_rx at CPB=10, HALF=5. The stimulus tasks know what each
// frame means on the wire and queue the strobe it must produce (kind, data,
// due cycle from the latency formula); one monitor compares every cycle.
module tb_fsm_uart_rx;

  localparam int CLK_FREQ  = 1_000_000;
  localparam int BAUD      = 100_000;
  localparam int DATA_BITS = 8;
  localparam int CPB       = CLK_FREQ / BAUD;
  localparam int HALF      = CPB / 2;

  typedef struct {
    bit       err;
    bit [7:0] data;
    int       t0;
    int       due;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_i = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  int       cyc = 0;
  int       n_vec = 0;
  int       n_err = 0;
  int       last_lat = -1;
  bit [7:0] model_data = '0;
  ev_t      q[$];

  fsm_uart_rx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .DATA_BITS (DATA_BITS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_i      (rx_i),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Drive the line for n cycles; entered and left at posedge + 1.
  task automatic hold(input logic v, input int n);
    rx_i = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // First low clk edge is t0+1; strobe due 2 + HALF + (DATA_BITS+1)*CPB later.
  function automatic int due_of(input int t0);
    return t0 + 1 + 2 + HALF + (DATA_BITS + 1) * CPB;
  endfunction

  task automatic send_frame(input bit [7:0] b, input bit stop_ok, input int gap,
                            input bit abort);
    int t0;
    ev_t e;
    t0 = cyc;
    hold(1'b0, CPB);
    for (int i = 0; i < DATA_BITS; i++) begin
      if (abort && i == 3) begin
        rst_n = 1'b0;
        hold(1'b1, 5);
        rst_n = 1'b1;
        hold(1'b1, 20);
        return;
      end
      hold(b[i], CPB);
    end
    e.err = !stop_ok; e.data = b; e.t0 = t0; e.due = due_of(t0);
    q.push_back(e);
    hold(stop_ok, CPB);
    chk("busy_after_frame", int'(busy), 0);
    if (gap > 0) hold(1'b1, gap);
  endtask

  task automatic glitch(input int len);
    int nb;
    nb = 0;
    hold(1'b0, len);
    for (int i = 0; i < 20; i++) begin
      if (busy) nb++;
      hold(1'b1, 1);
    end
    chk("glitch_busy_max8", int'(nb <= 8), 1);
    chk("glitch_busy_seen", int'(nb >= 1), 1);
  endtask

  // Per-cycle monitor
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        model_data = '0;
        chk("rst_rx_valid", int'(rx_valid), 0);
        chk("rst_frame_err", int'(frame_err), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_rx_data", int'(rx_data), 0);
      end else begin
        chk("valid_err_excl", int'(rx_valid & frame_err), 0);
        if (rx_valid || frame_err) begin
          if (q.size() == 0) begin
            chk("spurious_strobe", int'({rx_valid, frame_err}), 0);
          end else begin
            e = q.pop_front();
            chk("strobe_kind_err", int'(frame_err), int'(e.err));
            chk("strobe_on_time", int'(cyc >= e.due - 1 && cyc <= e.due + 1), 1);
            last_lat = cyc - e.t0;
            if (!e.err) model_data = e.data;
          end
        end else if (q.size() > 0 && cyc > q[0].due + 1) begin
          chk("missed_strobe", 0, 1);
          e = q.pop_front();
        end
        chk("rx_data", int'(rx_data), int'(model_data));
      end
    end
  end

  initial begin
    ev_t e;
    int  t0;
    int  kind;
    int  gap;
    rst_n = 1'b0;
    rx_i  = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b1;
    hold(1'b1, 20);
    chk("idle_busy", int'(busy), 0);

    // Single frame, with literal data and latency pins
    send_frame(8'hA5, 1'b1, 20, 1'b0);
    chk("a5_data", int'(rx_data), 'hA5);
    chk("a5_latency", int'(last_lat >= 97 && last_lat <= 99), 1);

    // Back-to-back frames, no idle gap
    send_frame(8'h00, 1'b1, 0, 1'b0);
    send_frame(8'hFF, 1'b1, 20, 1'b0);
    chk("b2b_data", int'(rx_data), 'hFF);

    // Short glitch on idle line
    glitch(3);

    // Bad stop bit keeps the previous byte
    send_frame(8'h3C, 1'b0, 20, 1'b0);
    chk("ferr_keeps_data", int'(rx_data), 'hFF);

    // Break: 30 bit times low gives exactly one frame error
    t0 = cyc;
    e.err = 1'b1; e.data = '0; e.t0 = t0; e.due = due_of(t0);
    q.push_back(e);
    hold(1'b0, 30 * CPB);
    chk("break_busy", int'(busy), 0);
    hold(1'b1, 30);
    send_frame(8'h55, 1'b1, 20, 1'b0);
    chk("after_break_data", int'(rx_data), 'h55);

    // Reset mid-DATA, then the same byte intact
    send_frame(8'h81, 1'b1, 0, 1'b1);
    chk("after_rst_data", int'(rx_data), 0);
    send_frame(8'h81, 1'b1, 20, 1'b0);
    chk("rst_retry_data", int'(rx_data), 'h81);

    // Random traffic
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 9);
      gap  = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(2, 25);
      if (kind == 0) begin
        glitch($urandom_range(1, 3));
      end else if (kind == 1) begin
        send_frame(8'($urandom), 1'b0, gap < 2 ? 2 : gap, 1'b0);
      end else begin
        send_frame(8'($urandom), 1'b1, gap, 1'b0);
      end
    end

    hold(1'b1, 150);
    chk("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
